ysyx_25040105_lsu: RTL and testbench

YSYX_25040105_LSU -- requirements
Module: ysyx_25040105_LSU

---
 rtl/ysyx_25040105_pkg.sv | 45 ++++
 rtl/ysyx_25040105_lsu_if.sv | 22 ++
 rtl/ysyx_25040105_lsu_align.sv | 40 ++++
 rtl/ysyx_25040105_lsu.sv | 142 ++++++++++++++
 tb/tb_ysyx_25040105_lsu.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_25040105_pkg.sv
// Shared encodings for the load/store unit: access sizes, funct3 codes,
// FSM state values and exception cause codes.
package ysyx_25040105_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] EXC_NONE   = 2'b00;
  localparam logic [1:0] EXC_LD_MIS = 2'b01;
  localparam logic [1:0] EXC_ST_MIS = 2'b10;
  localparam logic [1:0] EXC_BUS    = 2'b11;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Any funct3 outside the five legal codes is handled as a word access.
  function automatic size_e access_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: access_size = SZ_B;
      F3_H, F3_HU: access_size = SZ_H;
      F3_W:        access_size = SZ_W;
      default:     access_size = SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
    case (size)
      SZ_H:    is_misaligned = lo[0];
      SZ_W:    is_misaligned = (lo != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25040105_lsu_if.sv
// Memory-side request/response bus of the load/store unit.
interface ysyx_25040105_lsu_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        mem_resp_err;

  modport master (
    output mem_req_valid, mem_addr, mem_wdata, mem_we, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_wdata, mem_we, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
  );
endinterface

// File: rtl/ysyx_25040105_lsu_align.sv
// Byte-lane steering: store mask/data placement and load extraction with
// sign or zero extension.
module ysyx_25040105_lsu_align
  import ysyx_25040105_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  size_e       size;
  logic [31:0] shifted;

  always_comb begin
    size    = access_size(funct3);
    wdata   = st_data << {offset, 3'b000};
    shifted = ld_raw >> {offset, 3'b000};
    wmask   = 4'b1111;
    ld_data = shifted;
    case (size)
      SZ_B: begin
        wmask   = 4'b0001 << offset;
        ld_data = funct3[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        wmask   = 4'b0011 << offset;
        ld_data = funct3[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        wmask   = 4'b1111;
        ld_data = shifted;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_25040105_lsu.sv
// Load/store unit: accepts one op from execute, performs at most one bus
// access, and hands the writeback payload downstream.
module ysyx_25040105_lsu
  import ysyx_25040105_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_rs2_data,
  input  logic        in_mem_ren,
  input  logic        in_mem_wen,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_wen,
  ysyx_25040105_lsu_if.master mem,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [4:0]  out_rd,
  output logic        out_rd_wen,
  output logic [31:0] out_wdata,
  output logic        out_exc,
  output logic [1:0]  out_exc_cause
);

  logic [1:0]  state_q;
  logic [31:0] pc_q, addr_q, rs2_q;
  logic        ld_q, st_q, rd_wen_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic [31:0] res_wdata_q;
  logic        res_rd_wen_q, res_exc_q;
  logic [1:0]  res_cause_q;

  logic        accept, in_ld, in_st, in_mis;
  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata, ld_data;

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  // Both enables high is resolved as a load.
  assign in_ld    = in_mem_ren;
  assign in_st    = in_mem_wen && !in_mem_ren;
  assign in_mis   = is_misaligned(access_size(in_funct3), in_alu_result[1:0]);

  ysyx_25040105_lsu_align u_align (
    .offset  (addr_q[1:0]),
    .funct3  (f3_q),
    .st_data (rs2_q),
    .ld_raw  (mem.mem_rdata),
    .wmask   (lane_mask),
    .wdata   (lane_wdata),
    .ld_data (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      addr_q       <= '0;
      rs2_q        <= '0;
      ld_q         <= 1'b0;
      st_q         <= 1'b0;
      f3_q         <= '0;
      rd_q         <= '0;
      rd_wen_q     <= 1'b0;
      res_wdata_q  <= '0;
      res_rd_wen_q <= 1'b0;
      res_exc_q    <= 1'b0;
      res_cause_q  <= EXC_NONE;
    end else if (accept) begin
      pc_q     <= in_pc;
      addr_q   <= in_alu_result;
      rs2_q    <= in_rs2_data;
      ld_q     <= in_ld;
      st_q     <= in_st;
      f3_q     <= in_funct3;
      rd_q     <= in_rd;
      rd_wen_q <= in_rd_wen;
      if (!(in_ld || in_st)) begin
        state_q      <= ST_DONE;
        res_wdata_q  <= in_alu_result;
        res_rd_wen_q <= in_rd_wen;
        res_exc_q    <= 1'b0;
        res_cause_q  <= EXC_NONE;
      end else if (in_mis) begin
        state_q      <= ST_DONE;
        res_wdata_q  <= '0;
        res_rd_wen_q <= 1'b0;
        res_exc_q    <= 1'b1;
        res_cause_q  <= in_ld ? EXC_LD_MIS : EXC_ST_MIS;
      end else begin
        state_q      <= ST_REQ;
        res_wdata_q  <= '0;
        res_rd_wen_q <= 1'b0;
        res_exc_q    <= 1'b0;
        res_cause_q  <= EXC_NONE;
      end
    end else begin
      case (state_q)
        ST_REQ:  if (mem.mem_req_ready) state_q <= ST_WAIT;
        ST_WAIT: begin
          if (mem.mem_resp_valid) begin
            state_q <= ST_DONE;
            if (mem.mem_resp_err) begin
              res_wdata_q  <= '0;
              res_rd_wen_q <= 1'b0;
              res_exc_q    <= 1'b1;
              res_cause_q  <= EXC_BUS;
            end else if (ld_q) begin
              res_wdata_q  <= ld_data;
              res_rd_wen_q <= rd_wen_q;
            end else begin
              res_wdata_q  <= '0;
              res_rd_wen_q <= 1'b0;
            end
          end
        end
        ST_DONE: if (out_ready) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem.mem_req_valid = (state_q == ST_REQ);
  assign mem.mem_addr      = {addr_q[31:2], 2'b00};
  assign mem.mem_wdata     = lane_wdata;
  assign mem.mem_we        = st_q;
  assign mem.mem_wmask     = st_q ? lane_mask : 4'b0000;

  assign out_valid     = (state_q == ST_DONE);
  assign out_pc        = pc_q;
  assign out_rd        = rd_q;
  assign out_rd_wen    = res_rd_wen_q;
  assign out_wdata     = res_wdata_q;
  assign out_exc       = res_exc_q;
  assign out_exc_cause = res_cause_q;

endmodule

// File: tb/tb_ysyx_25040105_lsu.sv
// Randomised and directed checks of the load/store unit against a
// byte-level reference model.
module tb_ysyx_25040105_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_alu_result, in_rs2_data;
  logic        in_mem_ren, in_mem_wen;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_wdata;
  logic [4:0]  out_rd;
  logic        out_rd_wen, out_exc;
  logic [1:0]  out_exc_cause;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_25040105_lsu_if mem_bus ();

  ysyx_25040105_lsu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_alu_result (in_alu_result),
    .in_rs2_data   (in_rs2_data),
    .in_mem_ren    (in_mem_ren),
    .in_mem_wen    (in_mem_wen),
    .in_funct3     (in_funct3),
    .in_rd         (in_rd),
    .in_rd_wen     (in_rd_wen),
    .mem           (mem_bus),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_rd        (out_rd),
    .out_rd_wen    (out_rd_wen),
    .out_wdata     (out_wdata),
    .out_exc       (out_exc),
    .out_exc_cause (out_exc_cause)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference behaviour expressed in bytes and integer arithmetic.
  task automatic model(
    input  logic [31:0] alu, rs2, rdata,
    input  logic        ren, wen, err, rdw,
    input  logic [2:0]  f3,
    output logic        exp_req, exp_st,
    output logic [31:0] exp_addr, exp_bus,
    output logic [3:0]  exp_mask,
    output logic        exp_exc,
    output logic [1:0]  exp_cause,
    output logic        exp_rdw,
    output logic [31:0] exp_wdata
  );
    longint sz, off, v, a, r, d;
    logic   is_mem, mis;
    a  = longint'(alu);
    r  = longint'(rs2);
    d  = longint'(rdata);
    sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    off      = a % 4;
    is_mem   = ren || wen;
    exp_st   = wen && !ren;
    mis      = is_mem && ((a % sz) != 0);
    exp_req  = is_mem && !mis;
    exp_addr = 32'(a - off);
    exp_mask = '0;
    exp_bus  = '0;
    for (longint j = 0; j < 4; j++) begin
      if (j < sz) exp_mask = exp_mask | 4'(1 << (off + j));
      if (off + j < 4) exp_bus = exp_bus + 32'(((r >> (8 * j)) % 256) << (8 * (off + j)));
    end
    v = 0;
    for (longint j = 0; j < sz; j++) v = v + (((d >> (8 * (off + j))) % 256) << (8 * j));
    if (sz < 4 && f3 < 3'd4 && v >= (64'sd1 << (8 * sz - 1))) v = v - (64'sd1 << (8 * sz));
    exp_exc = 1'b0; exp_cause = 2'b00; exp_rdw = 1'b0; exp_wdata = '0;
    if (!is_mem) begin
      exp_rdw = rdw; exp_wdata = alu;
    end else if (mis) begin
      exp_exc = 1'b1; exp_cause = ren ? 2'b01 : 2'b10;
    end else if (err) begin
      exp_exc = 1'b1; exp_cause = 2'b11;
    end else if (ren) begin
      exp_rdw = rdw; exp_wdata = 32'(v);
    end
  endtask

  task automatic do_txn(
    input  logic [31:0] pc, alu, rs2,
    input  logic        ren, wen,
    input  logic [2:0]  f3,
    input  logic [4:0]  rd,
    input  logic        rdw,
    input  logic [31:0] rdata,
    input  logic        err,
    input  int          req_stall, resp_dly, out_stall,
    output logic [31:0] got_wdata, got_bus,
    output logic [3:0]  got_mask
  );
    logic        e_req, e_st, e_exc, e_rdw;
    logic [31:0] e_addr, e_bus, e_wd;
    logic [3:0]  e_mask;
    logic [1:0]  e_cause;
    model(alu, rs2, rdata, ren, wen, err, rdw, f3, e_req, e_st, e_addr, e_bus, e_mask,
          e_exc, e_cause, e_rdw, e_wd);
    got_bus = '0; got_mask = '0; got_wdata = '0;
    check_eq("idle_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_pc = pc; in_alu_result = alu; in_rs2_data = rs2;
    in_mem_ren = ren; in_mem_wen = wen; in_funct3 = f3; in_rd = rd; in_rd_wen = rdw;
    #1 check_eq("accept_cycle_no_req", 32'(mem_bus.mem_req_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0; in_alu_result = $urandom; in_rs2_data = $urandom; in_pc = $urandom;
    if (e_req) begin
      for (int i = 0; i <= req_stall; i++) begin
        check_eq("req_valid", 32'(mem_bus.mem_req_valid), 32'd1);
        check_eq("req_addr", mem_bus.mem_addr, e_addr);
        check_eq("req_we", 32'(mem_bus.mem_we), 32'(e_st));
        if (e_st) begin
          check_eq("req_wmask", 32'(mem_bus.mem_wmask), 32'(e_mask));
          check_eq("req_wdata", mem_bus.mem_wdata, e_bus);
        end
        check_eq("req_in_ready", 32'(in_ready), 32'd0);
        check_eq("req_out_valid", 32'(out_valid), 32'd0);
        got_bus = mem_bus.mem_wdata; got_mask = mem_bus.mem_wmask;
        if (i == req_stall) mem_bus.mem_req_ready = 1'b1;
        else if ($urandom_range(0, 2) == 0) begin
          mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_rdata = $urandom; mem_bus.mem_resp_err = 1'b1;
        end
        @(negedge clk);
        mem_bus.mem_req_ready = 1'b0; mem_bus.mem_resp_valid = 1'b0; mem_bus.mem_resp_err = 1'b0;
      end
      for (int i = 0; i < resp_dly; i++) begin
        check_eq("wait_no_req", 32'(mem_bus.mem_req_valid), 32'd0);
        check_eq("wait_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
      end
      mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_rdata = rdata; mem_bus.mem_resp_err = err;
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b0; mem_bus.mem_rdata = $urandom; mem_bus.mem_resp_err = 1'b0;
    end else begin
      check_eq("no_req", 32'(mem_bus.mem_req_valid), 32'd0);
    end
    for (int i = 0; i <= out_stall; i++) begin
      check_eq("out_valid", 32'(out_valid), 32'd1);
      check_eq("out_pc", out_pc, pc);
      check_eq("out_rd", 32'(out_rd), 32'(rd));
      check_eq("out_rd_wen", 32'(out_rd_wen), 32'(e_rdw));
      check_eq("out_exc", 32'(out_exc), 32'(e_exc));
      if (e_exc) check_eq("out_exc_cause", 32'(out_exc_cause), 32'(e_cause));
      if (!e_exc || e_cause == 2'b11) check_eq("out_wdata", out_wdata, e_wd);
      check_eq("done_no_req", 32'(mem_bus.mem_req_valid), 32'd0);
      got_wdata = out_wdata;
      if (i == out_stall) begin
        out_ready = 1'b1;
        #1 check_eq("done_in_ready", 32'(in_ready), 32'd1);
      end else begin
        check_eq("stall_in_ready", 32'(in_ready), 32'd0);
        if ($urandom_range(0, 1) == 0) begin
          mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_rdata = $urandom; mem_bus.mem_resp_err = 1'b1;
        end
      end
      @(negedge clk);
      out_ready = 1'b0; mem_bus.mem_resp_valid = 1'b0; mem_bus.mem_resp_err = 1'b0;
    end
    check_eq("back_to_idle", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] wd, bus, alu;
    logic [3:0]  msk;
    logic        ren, wen;
    rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_alu_result = '0; in_rs2_data = '0;
    in_mem_ren = 1'b0; in_mem_wen = 1'b0; in_funct3 = '0; in_rd = '0; in_rd_wen = 1'b0;
    out_ready = 1'b0;
    mem_bus.mem_req_ready = 1'b0; mem_bus.mem_resp_valid = 1'b0;
    mem_bus.mem_rdata = '0; mem_bus.mem_resp_err = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_req_valid", 32'(mem_bus.mem_req_valid), 32'd0);
    check_eq("rst_out_exc", 32'(out_exc), 32'd0);
    check_eq("rst_out_rd_wen", 32'(out_rd_wen), 32'd0);
    check_eq("rst_out_wdata", out_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU passthrough, one-cycle latency
    do_txn(32'h100, 32'h1234, 32'h0, 1'b0, 1'b0, 3'd0, 5'd5, 1'b1, 32'h0, 1'b0, 0, 0, 0, wd, bus, msk);
    check_eq("add_wdata", wd, 32'h0000_1234);
    do_txn(32'h104, 32'h8000_0003, 32'h0, 1'b1, 1'b0, 3'd0, 5'd6, 1'b1, 32'h80FF_0000, 1'b0, 0, 1, 0, wd, bus, msk);
    check_eq("lb_wdata", wd, 32'hFFFF_FF80);
    do_txn(32'h108, 32'h8000_0003, 32'h0, 1'b1, 1'b0, 3'd4, 5'd6, 1'b1, 32'h80FF_0000, 1'b0, 0, 1, 0, wd, bus, msk);
    check_eq("lbu_wdata", wd, 32'h0000_0080);
    do_txn(32'h10C, 32'h8000_0002, 32'hABCD_1234, 1'b0, 1'b1, 3'd1, 5'd7, 1'b1, 32'h0, 1'b0, 0, 0, 0, wd, bus, msk);
    check_eq("sh_wmask", 32'(msk), 32'h0000_000C);
    check_eq("sh_wdata", bus, 32'h1234_0000);
    do_txn(32'h110, 32'h8000_0001, 32'h0, 1'b1, 1'b0, 3'd2, 5'd8, 1'b1, 32'h0, 1'b0, 0, 0, 0, wd, bus, msk);
    do_txn(32'h114, 32'h8000_0002, 32'h5, 1'b0, 1'b1, 3'd2, 5'd8, 1'b1, 32'h0, 1'b0, 0, 0, 0, wd, bus, msk);
    do_txn(32'h118, 32'h8000_0006, 32'h5, 1'b1, 1'b1, 3'd3, 5'd9, 1'b1, 32'h0, 1'b0, 0, 0, 0, wd, bus, msk);
    do_txn(32'h11C, 32'h8000_0040, 32'h0, 1'b1, 1'b0, 3'd2, 5'd9, 1'b1, 32'hDEAD_BEEF, 1'b1, 1, 2, 1, wd, bus, msk);
    do_txn(32'h120, 32'h8000_0044, 32'h0, 1'b1, 1'b0, 3'd2, 5'd10, 1'b1, 32'hCAFE_F00D, 1'b0, 5, 1, 3, wd, bus, msk);
    check_eq("lw_stall_wdata", wd, 32'hCAFE_F00D);

    // Back-to-back accept while the previous result drains
    in_valid = 1'b1; in_pc = 32'h200; in_alu_result = 32'hAAAA_0001; in_mem_ren = 1'b0;
    in_mem_wen = 1'b0; in_rd = 5'd1; in_rd_wen = 1'b1;
    @(negedge clk);
    in_pc = 32'h204; in_alu_result = 32'hBBBB_0002; in_rd = 5'd2; out_ready = 1'b1;
    check_eq("b2b_first_wdata", out_wdata, 32'hAAAA_0001);
    #1 check_eq("b2b_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("b2b_second_valid", 32'(out_valid), 32'd1);
    check_eq("b2b_second_pc", out_pc, 32'h204);
    check_eq("b2b_second_wdata", out_wdata, 32'hBBBB_0002);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset while waiting for the bus response, then a stale response
    in_valid = 1'b1; in_pc = 32'h300; in_alu_result = 32'h8000_0010; in_mem_ren = 1'b1;
    in_mem_wen = 1'b0; in_funct3 = 3'd2; in_rd = 5'd3; in_rd_wen = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; mem_bus.mem_req_ready = 1'b1;
    @(negedge clk);
    mem_bus.mem_req_ready = 1'b0;
    check_eq("rw_wait_no_req", 32'(mem_bus.mem_req_valid), 32'd0);
    rst_n = 1'b0;
    #1 check_eq("rw_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1; mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_rdata = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b0;
      check_eq("rw_out_valid", 32'(out_valid), 32'd0);
      check_eq("rw_idle", 32'(in_ready), 32'd1);
      check_eq("rw_rd_wen", 32'(out_rd_wen), 32'd0);
    end

    for (int n = 0; n < 250; n++) begin
      alu = $urandom;
      if ($urandom_range(0, 1) == 0) alu[1:0] = 2'b00;
      ren = ($urandom_range(0, 3) != 0) ? 1'(($urandom_range(0, 2) == 0)) : 1'b0;
      wen = ren ? 1'(($urandom_range(0, 5) == 0)) : 1'(($urandom_range(0, 1) == 0));
      do_txn($urandom, alu, $urandom, ren, wen, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), $urandom, 1'(($urandom_range(0, 7) == 0)),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), wd, bus, msk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
